seg7_scan_driver: RTL



---
 rtl/seg7_scan_driver_pkg.sv | 50 +++++
 rtl/seg7_scan_driver_if.sv | 25 ++
 rtl/seg7_scan_driver_hex_to_seg7.sv | 14 +
 rtl/seg7_scan_driver.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants, types and the hex-to-segment lookup for the
// seven-segment scan driver.
package seg7_scan_driver_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int NIB_W      = 4;
  localparam int DATA_W     = NUM_DIGITS * NIB_W;

  // Segment bit positions inside the 7-bit segment vector.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_W = SEG_G + 1;

  // Phase within one digit slot.
  typedef enum logic {
    PH_SHOW  = 1'b0,
    PH_BLANK = 1'b1
  } phase_e;

  // Active-high segment pattern for one hex nibble (bit 0 = a ... bit 6 = g).
  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIB_W-1:0] nib);
    logic [SEG_W-1:0] s;
    case (nib)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      4'hF:    s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle: the PIO word and controls in, the LED pins out.
interface seg7_scan_driver_if;
  import seg7_scan_driver_pkg::*;

  logic [DATA_W-1:0]     disp_data;
  logic [NUM_DIGITS-1:0] dp_mask;
  logic                  blank_lz;
  logic [SEG_W-1:0]      seg;
  logic                  dp;
  logic [NUM_DIGITS-1:0] dig;
  logic                  frame_tick;

  // Upstream side (PIO / bench) drives the word and watches the pins.
  modport master (
    output disp_data, dp_mask, blank_lz,
    input  seg, dp, dig, frame_tick
  );

  // The scan driver itself.
  modport slave (
    input  disp_data, dp_mask, blank_lz,
    output seg, dp, dig, frame_tick
  );

endinterface

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational nibble to active-high seven-segment pattern.
module hex_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [NIB_W-1:0] nibble_i,
  output logic [SEG_W-1:0] seg_o
);

  // Pure table lookup; the shared function keeps the table in one place.
  always_comb begin
    seg_o = hex_to_seg(nibble_i);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment driver with frame-latched shadow
// registers, leading-zero blanking and an anti-ghosting blank interval.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int BLANK_CYCLES   = 50,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  seg7_scan_driver_if.slave  disp_if
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  // One extra count of headroom so the show threshold never aliases.
  localparam int CNT_W = $clog2(DIV + 1);

  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]      CNT_SHOW = CNT_W'(DIV - BLANK_CYCLES);
  localparam logic [2:0]            IDX_LAST = 3'd7;
  localparam logic [NUM_DIGITS-1:0] DIG_ONE  = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
  localparam logic [SEG_W-1:0]      SEG_INV  = {SEG_W{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_INV  = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [DATA_W-1:0]     shadow_data_q, shadow_data_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic                  frame_tick_q, frame_tick_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;

  logic                  slot_end_s;
  logic                  reload_s;
  phase_e                phase_s;
  logic [NIB_W-1:0]      nibble_s;
  logic [SEG_W-1:0]      lut_seg_s;
  logic [NUM_DIGITS-1:0] lz_mask_s;
  logic                  zero_run_s;
  logic [SEG_W-1:0]      seg_log_s;
  logic                  dp_log_s;
  logic [NUM_DIGITS-1:0] dig_log_s;

  assign nibble_s = shadow_data_q[{idx_q, 2'b00} +: NIB_W];

  hex_to_seg7 u_lut (
    .nibble_i (nibble_s),
    .seg_o    (lut_seg_s)
  );

  // Slot/digit counters and the end-of-frame shadow reload.
  always_comb begin
    slot_end_s    = (cnt_q == CNT_LAST);
    reload_s      = slot_end_s && (idx_q == IDX_LAST);
    cnt_d         = cnt_q + CNT_W'(1);
    idx_d         = idx_q;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    if (slot_end_s) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
    end
    if (reload_s) begin
      shadow_data_d = disp_if.disp_data;
      shadow_dp_d   = disp_if.dp_mask;
    end else begin
      shadow_data_d = shadow_data_q;
      shadow_dp_d   = shadow_dp_q;
    end
    frame_tick_d = reload_s;
  end

  // Leading-zero mask: bit i set when nibbles 7..i of the shadow are all
  // zero; digit 0 always stays visible so a zero word shows one "0".
  always_comb begin
    lz_mask_s  = '0;
    zero_run_s = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run_s   = zero_run_s & (shadow_data_q[i*NIB_W +: NIB_W] == 4'h0);
      lz_mask_s[i] = zero_run_s;
    end
  end

  // Logical pin values for the current slot phase, then pin polarity.
  always_comb begin
    phase_s   = (cnt_q < CNT_SHOW) ? PH_SHOW : PH_BLANK;
    seg_log_s = '0;
    dp_log_s  = 1'b0;
    dig_log_s = '0;
    case (phase_s)
      PH_SHOW: begin
        seg_log_s = lut_seg_s;
        dp_log_s  = shadow_dp_q[idx_q];
        if (disp_if.blank_lz && lz_mask_s[idx_q]) begin
          dig_log_s = '0;
        end else begin
          dig_log_s = DIG_ONE << idx_q;
        end
      end
      PH_BLANK: begin
        seg_log_s = '0;
        dp_log_s  = 1'b0;
        dig_log_s = '0;
      end
      default: begin
        seg_log_s = '0;
        dp_log_s  = 1'b0;
        dig_log_s = '0;
      end
    endcase
    seg_d = seg_log_s ^ SEG_INV;
    dp_d  = dp_log_s ^ SEG_ACTIVE_LOW;
    dig_d = dig_log_s ^ DIG_INV;
  end

  // State and output registers; reset parks every pin at its inactive level.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q         <= '0;
      idx_q         <= 3'd0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      frame_tick_q  <= 1'b0;
      seg_q         <= SEG_INV;
      dp_q          <= SEG_ACTIVE_LOW;
      dig_q         <= DIG_INV;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      frame_tick_q  <= frame_tick_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      dig_q         <= dig_d;
    end
  end

  assign disp_if.seg        = seg_q;
  assign disp_if.dp         = dp_q;
  assign disp_if.dig        = dig_q;
  assign disp_if.frame_tick = frame_tick_q;

endmodule
